conv1d_tap_window: RTL and testbench

Upstream feeder for the conv1d 4:1 tap multiplexer. Collects input samples into a 4-deep sliding window and presents all four taps in parallel to the mux data inputs. For each new full window it steps the 2-bit mux select through 0..3 under a valid/ready handshake, so the downstream serial MAC consumes one tap per accepted cycle.

---
 rtl/conv1d_tap_window.sv | 115 +++++++++++
 tb/tb_conv1d_tap_window.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/conv1d_tap_window.sv
// conv1d_tap_window: 4-deep sliding sample window feeding the conv1d 4:1 tap
// mux. Each new full window is followed by a four-step tap sequence (sel 0..3)
// handed to the downstream serial MAC over a valid/ready handshake.
//
// Handshake semantics (both ports):
//   A transfer happens at a rising clk edge where valid and ready are both 1.
//   Upstream: in_ready is a pure function of state and never looks at in_valid.
//   Downstream: tap_valid, sel and the taps hold steady until a transfer.
module conv1d_tap_window #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] tap0,
  output logic [N-1:0] tap1,
  output logic [N-1:0] tap2,
  output logic [N-1:0] tap3,
  output logic [1:0]   sel,
  output logic         tap_valid,
  input  logic         tap_ready,
  output logic         tap_first,
  output logic         tap_last,
  output logic         window_full
);

  // Sequencer states. The state register is named 'state' so checkers can
  // bind to it directly.
  localparam logic [1:0] ST_FILL  = 2'd0;  // fewer than four samples held
  localparam logic [1:0] ST_READY = 2'd1;  // window full, waiting for a sample
  localparam logic [1:0] ST_SEQ   = 2'd2;  // stepping sel through 0..3

  logic [1:0] state;
  logic [2:0] count;
  logic       accept;
  logic       tap_hs;

  assign in_ready    = (state != ST_SEQ);
  assign accept      = in_valid && in_ready;
  assign tap_valid   = (state == ST_SEQ);
  assign tap_hs      = tap_valid && tap_ready;
  assign tap_first   = tap_valid && (sel == 2'd0);
  assign tap_last    = tap_valid && (sel == 2'd3);
  assign window_full = (count == 3'd4);

  // Sample shift register and saturating fill counter; clear wins over accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap0  <= '0;
      tap1  <= '0;
      tap2  <= '0;
      tap3  <= '0;
      count <= 3'd0;
    end else if (clear) begin
      tap0  <= '0;
      tap1  <= '0;
      tap2  <= '0;
      tap3  <= '0;
      count <= 3'd0;
    end else if (accept) begin
      tap3 <= tap2;
      tap2 <= tap1;
      tap1 <= tap0;
      tap0 <= in_data;
      if (count != 3'd4) begin
        count <= count + 3'd1;
      end
    end
  end

  // Sequencer: enter SEQ on the accept that completes (or refreshes) a full
  // window, step sel on each downstream transfer, leave after the sel==3 one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      sel   <= 2'd0;
    end else if (clear) begin
      state <= ST_FILL;
      sel   <= 2'd0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept && (count == 3'd3)) begin
            state <= ST_SEQ;
            sel   <= 2'd0;
          end
        end
        ST_READY: begin
          if (accept) begin
            state <= ST_SEQ;
            sel   <= 2'd0;
          end
        end
        ST_SEQ: begin
          if (tap_hs) begin
            if (sel == 2'd3) begin
              state <= ST_READY;
              sel   <= 2'd0;
            end else begin
              sel <= sel + 2'd1;
            end
          end
        end
        default: begin
          state <= ST_FILL;
          sel   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_tap_window.sv
// tb_conv1d_tap_window: directed scenarios plus randomized traffic, checked
// every cycle against a window/sequence model kept in the bench.
module tb_conv1d_tap_window;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] tap0, tap1, tap2, tap3;
  logic [1:0]   sel;
  logic         tap_valid;
  logic         tap_ready;
  logic         tap_first;
  logic         tap_last;
  logic         window_full;

  conv1d_tap_window #(.N(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tap0        (tap0),
    .tap1        (tap1),
    .tap2        (tap2),
    .tap3        (tap3),
    .sel         (sel),
    .tap_valid   (tap_valid),
    .tap_ready   (tap_ready),
    .tap_first   (tap_first),
    .tap_last    (tap_last),
    .window_full (window_full)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the window newest-first; seq_idx is the tap being offered
  // (-1 when no sequence is running); filled counts samples since flush.
  logic [W-1:0] exp_q[$];
  int           filled;
  int           seq_idx;
  int           tests;
  int           fails;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    repeat (4) exp_q.push_back('0);
    filled  = 0;
    seq_idx = -1;
  endtask

  task automatic model_edge(input logic clr, input logic v, input logic [W-1:0] d,
                            input logic tr);
    if (clr) begin
      model_flush();
    end else if (seq_idx >= 0) begin
      if (tr) seq_idx = (seq_idx == 3) ? -1 : seq_idx + 1;
    end else if (v) begin
      exp_q.push_front(d);
      void'(exp_q.pop_back());
      if (filled < 4) filled++;
      if (filled == 4) seq_idx = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [1:0] es;
    es = (seq_idx >= 0) ? seq_idx[1:0] : 2'd0;
    check({ctx, ".tap0"}, 32'(tap0), 32'(exp_q[0]));
    check({ctx, ".tap1"}, 32'(tap1), 32'(exp_q[1]));
    check({ctx, ".tap2"}, 32'(tap2), 32'(exp_q[2]));
    check({ctx, ".tap3"}, 32'(tap3), 32'(exp_q[3]));
    check({ctx, ".sel"}, 32'(sel), 32'(es));
    check({ctx, ".tap_valid"}, 32'(tap_valid), 32'(seq_idx >= 0));
    check({ctx, ".tap_first"}, 32'(tap_first), 32'(seq_idx == 0));
    check({ctx, ".tap_last"}, 32'(tap_last), 32'(seq_idx == 3));
    check({ctx, ".window_full"}, 32'(window_full), 32'(filled == 4));
    check({ctx, ".in_ready"}, 32'(in_ready), 32'(seq_idx < 0));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs (called at a negedge), let the edge happen,
  // advance the model, then check on the following negedge.
  task automatic cycle(input string ctx, input logic v, input logic [W-1:0] d,
                       input logic tr, input logic clr);
    in_valid  = v;
    in_data   = d;
    tap_ready = tr;
    clear     = clr;
    @(posedge clk);
    model_edge(clr, v, d, tr);
    @(negedge clk);
    check_all(ctx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    tap_ready = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // Fill with 1,2,3: still filling, no taps offered.
    for (int i = 1; i <= 3; i++) cycle("fill", 1'b1, W'(i), 1'b1, 1'b0);
    // Fourth sample starts the sequence one cycle later.
    cycle("fill4", 1'b1, W'(4), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("seq", 1'b0, '0, 1'b1, 1'b0);

    // New sample 5 with a 3-cycle stall at sel==1; in_valid held high.
    cycle("acc5", 1'b1, W'(5), 1'b1, 1'b0);
    cycle("step0", 1'b1, W'(7), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, W'(8), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("resume", 1'b1, W'(8), 1'b1, 1'b0);
    cycle("idle", 1'b0, '0, 1'b1, 1'b0);

    // Clear at sel==2 with a sample presented; the sample must be dropped.
    cycle("acc6", 1'b1, W'(6), 1'b1, 1'b0);
    cycle("to_sel1", 1'b0, '0, 1'b1, 1'b0);
    cycle("to_sel2", 1'b0, '0, 1'b1, 1'b0);
    cycle("clear", 1'b1, W'(9), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, W'(16'h10 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("refill_seq", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            W'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) == 0));
    end

    // Async reset in the middle of a sequence, all-ones samples.
    for (int i = 0; i < 3; i++) cycle("ones", 1'b1, 16'hFFFF, 1'b1, 1'b0);
    begin
      int budget;
      budget = 20;
      while (seq_idx < 0 && budget > 0) begin
        cycle("ones_wait", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        budget--;
      end
      check("reach_seq", 32'(seq_idx >= 0), 32'd1);
    end
    cycle("ones_step", 1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_flush();
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("after_rst", 1'b1, 16'hFFFF, 1'b1, 1'b0);
    cycle("after_rst4", 1'b1, 16'hABCD, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("after_rst_seq", 1'b1, W'($urandom), 1'b1, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
